// File: rtl/hex_rotate_scheduler_if.sv
// Control and select bundle between the board keys/switches and the rotation scheduler.
// The master side drives the requests; the slave side (the scheduler) drives the select.
interface hex_rotate_scheduler_if;
  logic       enable;
  logic       dir;
  logic       step;
  logic       load;
  logic [1:0] loadval;
  logic [1:0] s;
  logic       tick;
  logic       running;

  modport master (
    output enable, dir, step, load, loadval,
    input  s, tick, running
  );

  modport slave (
    input  enable, dir, step, load, loadval,
    output s, tick, running
  );
endinterface

// File: rtl/hex_rotate_scheduler.sv
// Drives the 2-bit rotation select of the HEX rotator: prescaled auto stepping,
// pause, direction, debounced-by-edge manual step and direct load.
//
// state | meaning
// PAUSE | prescaler held at 0, only manual step or load move the select
// RUN   | prescaler counting, auto step every TICKS_PER_STEP cycles
module hex_rotate_scheduler #(
  parameter int TICKS_PER_STEP = 50_000_000
) (
  input logic                  clock,
  input logic                  resetn,
  hex_rotate_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(TICKS_PER_STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       s_q;
  logic [1:0]       s_d;
  logic             tick_q;
  logic             tick_d;
  logic             sync1_q;
  logic             sync2_q;
  logic             sync3_q;
  logic             valid1_q;
  logic             valid2_q;
  logic             armed_q;
  logic             man_step;
  logic             auto_step;

  function automatic logic [1:0] advance(input logic [1:0] cur, input logic back);
    logic [1:0] nxt;
    if (back) nxt = (cur == 2'd0) ? 2'd2 : cur - 2'd1;
    else      nxt = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    return nxt;
  endfunction

  // Step key synchronizer. armed_q only rises once a low level has been seen
  // through a fully refilled synchronizer, so a key held across reset is ignored.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= bus.step;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      valid1_q <= 1'b1;
      valid2_q <= valid1_q;
      armed_q  <= armed_q | (valid2_q & ~sync2_q);
    end
  end

  assign man_step  = sync2_q & ~sync3_q & armed_q;
  assign auto_step = (state_q == RUN) && (cnt_q == CNT_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= PAUSE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PAUSE:   if (bus.enable)  state_d = RUN;
      RUN:     if (!bus.enable) state_d = PAUSE;
      default: state_d = PAUSE;
    endcase
  end

  // Load beats manual step beats auto step; a load swallows any step that cycle.
  always_comb begin
    s_d    = s_q;
    tick_d = 1'b0;
    if (state_q == PAUSE || auto_step) cnt_d = '0;
    else                               cnt_d = cnt_q + CNT_W'(1);

    if (bus.load) begin
      s_d   = (bus.loadval == 2'd3) ? 2'd0 : bus.loadval;
      cnt_d = '0;
    end else if (man_step) begin
      s_d    = advance(s_q, bus.dir);
      cnt_d  = '0;
      tick_d = 1'b1;
    end else if (auto_step) begin
      s_d    = advance(s_q, bus.dir);
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      s_q    <= 2'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      s_q    <= s_d;
      tick_q <= tick_d;
    end
  end

  assign bus.s       = s_q;
  assign bus.tick    = tick_q;
  assign bus.running = (state_q == RUN);

endmodule

// File: tb/tb_hex_rotate_scheduler.sv
// Directed bench for hex_rotate_scheduler with a 4-cycle step interval.
module tb_hex_rotate_scheduler;

  logic clock;
  logic resetn;
  int   checks;
  int   errors;

  hex_rotate_scheduler_if bus ();

  hex_rotate_scheduler #(.TICKS_PER_STEP(4)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    resetn      = 1'b0;
    bus.enable  = 1'($urandom_range(0, 1));
    bus.dir     = 1'($urandom_range(0, 1));
    bus.step    = 1'b0;
    bus.load    = 1'($urandom_range(0, 1));
    bus.loadval = 2'($urandom_range(0, 3));
    repeat (3) @(negedge clock);
    checks++; if (bus.s !== 2'd0) begin errors++; $display("FAIL reset_s got %0d want 0", bus.s); end
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", bus.tick); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", bus.running); end
    bus.enable  = 1'b0;
    bus.dir     = 1'b0;
    bus.load    = 1'b0;
    bus.loadval = 2'd0;
    resetn      = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clock);
      checks++;
      if (bus.s !== 2'd0 || bus.running !== 1'b0)
        begin errors++; $display("FAIL idle_pause cyc %0d got s=%0d run=%b want s=0 run=0", j, bus.s, bus.running); end
    end
  endtask

  task automatic test_auto_forward();
    logic [1:0] exp_s;
    logic       exp_tick;
    bus.enable = 1'b1;
    bus.dir    = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clock);
      exp_s    = 2'(((j - 1) / 4) % 3);
      exp_tick = (j > 1) && ((j - 1) % 4 == 0);
      checks++;
      if (bus.s !== exp_s || bus.tick !== exp_tick || bus.running !== 1'b1)
        begin errors++; $display("FAIL auto_fwd edge %0d got s=%0d tick=%b run=%b want s=%0d tick=%b run=1",
                                 j, bus.s, bus.tick, bus.running, exp_s, exp_tick); end
    end
    // Enable drops on the very edge the auto step fires: step still taken.
    bus.enable = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd2 || bus.tick !== 1'b1 || bus.running !== 1'b0)
      begin errors++; $display("FAIL pause_on_step got s=%0d tick=%b run=%b want s=2 tick=1 run=0", bus.s, bus.tick, bus.running); end
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd2 || bus.tick !== 1'b0)
      begin errors++; $display("FAIL paused_hold got s=%0d tick=%b want s=2 tick=0", bus.s, bus.tick); end
  endtask

  task automatic test_backward();
    logic [1:0] seq [4];
    logic [1:0] exp_s;
    logic       exp_tick;
    seq[0] = 2'd0; seq[1] = 2'd2; seq[2] = 2'd1; seq[3] = 2'd0;
    bus.load    = 1'b1;
    bus.loadval = 2'd0;
    bus.dir     = 1'b1;
    bus.enable  = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd0 || bus.tick !== 1'b0 || bus.running !== 1'b1)
      begin errors++; $display("FAIL bwd_load got s=%0d tick=%b run=%b want s=0 tick=0 run=1", bus.s, bus.tick, bus.running); end
    bus.load = 1'b0;
    for (int j = 2; j <= 13; j++) begin
      @(negedge clock);
      exp_s    = seq[(j - 1) / 4];
      exp_tick = ((j - 1) % 4 == 0);
      checks++;
      if (bus.s !== exp_s || bus.tick !== exp_tick)
        begin errors++; $display("FAIL auto_bwd edge %0d got s=%0d tick=%b want s=%0d tick=%b", j, bus.s, bus.tick, exp_s, exp_tick); end
    end
    bus.load    = 1'b1;
    bus.loadval = 2'd2;
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd2 || bus.tick !== 1'b0)
      begin errors++; $display("FAIL load2 got s=%0d tick=%b want s=2 tick=0", bus.s, bus.tick); end
    bus.loadval = 2'd3;
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd0 || bus.tick !== 1'b0)
      begin errors++; $display("FAIL load3 got s=%0d tick=%b want s=0 tick=0", bus.s, bus.tick); end
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd0 || bus.running !== 1'b0)
      begin errors++; $display("FAIL bwd_pause got s=%0d run=%b want s=0 run=0", bus.s, bus.running); end
  endtask

  task automatic test_manual_step();
    logic [1:0] exp_s;
    logic       exp_tick;
    bus.dir  = 1'b0;
    bus.step = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      exp_s    = (j >= 2) ? 2'd1 : 2'd0;
      exp_tick = (j == 2);
      checks++;
      if (bus.s !== exp_s || bus.tick !== exp_tick)
        begin errors++; $display("FAIL man_hold cyc %0d got s=%0d tick=%b want s=%0d tick=%b", j, bus.s, bus.tick, exp_s, exp_tick); end
      if (j == 9) bus.step = 1'b0;
    end
    repeat (3) @(negedge clock);
    bus.step = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.s !== 2'd1 || bus.tick !== 1'b0)
      begin errors++; $display("FAIL man2_early got s=%0d tick=%b want s=1 tick=0", bus.s, bus.tick); end
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd2 || bus.tick !== 1'b1)
      begin errors++; $display("FAIL man2_step got s=%0d tick=%b want s=2 tick=1", bus.s, bus.tick); end
    bus.step = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd2 || bus.tick !== 1'b0)
      begin errors++; $display("FAIL man2_after got s=%0d tick=%b want s=2 tick=0", bus.s, bus.tick); end
  endtask

  task automatic test_priority();
    logic [1:0] exp_s;
    logic       exp_tick;
    bus.enable = 1'b1;
    bus.dir    = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.step = 1'b1;
    @(negedge clock);
    @(negedge clock);
    bus.load    = 1'b1;
    bus.loadval = 2'd1;
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd1 || bus.tick !== 1'b0 || bus.running !== 1'b1)
      begin errors++; $display("FAIL prio_load got s=%0d tick=%b run=%b want s=1 tick=0 run=1", bus.s, bus.tick, bus.running); end
    bus.load = 1'b0;
    for (int j = 6; j <= 9; j++) begin
      @(negedge clock);
      exp_s    = (j == 9) ? 2'd2 : 2'd1;
      exp_tick = (j == 9);
      checks++;
      if (bus.s !== exp_s || bus.tick !== exp_tick)
        begin errors++; $display("FAIL prio_restart edge %0d got s=%0d tick=%b want s=%0d tick=%b", j, bus.s, bus.tick, exp_s, exp_tick); end
    end
    bus.step   = 1'b0;
    bus.enable = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd2 || bus.running !== 1'b0)
      begin errors++; $display("FAIL prio_pause got s=%0d run=%b want s=2 run=0", bus.s, bus.running); end
  endtask

  task automatic test_async_reset();
    bus.load    = 1'b1;
    bus.loadval = 2'd1;
    @(negedge clock);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    bus.step   = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (bus.s !== 2'd2 || bus.running !== 1'b1)
      begin errors++; $display("FAIL pre_reset got s=%0d run=%b want s=2 run=1", bus.s, bus.running); end
    #2;
    resetn     = 1'b0;
    bus.enable = 1'b0;
    #1;
    checks++;
    if (bus.s !== 2'd0 || bus.tick !== 1'b0 || bus.running !== 1'b0)
      begin errors++; $display("FAIL async_reset got s=%0d tick=%b run=%b want s=0 tick=0 run=0", bus.s, bus.tick, bus.running); end
    #1;
    resetn = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      checks++;
      if (bus.s !== 2'd0 || bus.tick !== 1'b0)
        begin errors++; $display("FAIL held_step cyc %0d got s=%0d tick=%b want s=0 tick=0", j, bus.s, bus.tick); end
    end
    bus.step = 1'b0;
    repeat (3) @(negedge clock);
    bus.step = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.s !== 2'd0)
      begin errors++; $display("FAIL repress_early got s=%0d want 0", bus.s); end
    @(negedge clock);
    checks++;
    if (bus.s !== 2'd1 || bus.tick !== 1'b1)
      begin errors++; $display("FAIL repress_step got s=%0d tick=%b want s=1 tick=1", bus.s, bus.tick); end
    bus.step = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_auto_forward();
    test_backward();
    test_manual_step();
    test_priority();
    test_async_reset();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
